// File: rtl/traffic_pkg.sv
// Shared types and light encodings for the multi-approach signal controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GREEN,
    YELLOW,
    ALLRED,
    FLASH,
    PRESET
  } state_t;

  // Head encoding is {G,Y,R}
  localparam logic [2:0] LED_OFF = 3'b000;
  localparam logic [2:0] LED_G   = 3'b100;
  localparam logic [2:0] LED_Y   = 3'b010;
  localparam logic [2:0] LED_R   = 3'b001;

  function automatic int sec2cyc(input int sec, input int clk_per_sec);
    return sec * clk_per_sec;
  endfunction

endpackage

// File: rtl/phase_arbiter.sv
// Picks the next approach to serve: first demanding index after the current
// one (wrapping, current last), or simply current+1 when nobody is waiting.
module phase_arbiter #(
  parameter int N_PHASES = 4,
  parameter int IDX_W    = $clog2(N_PHASES)
) (
  input  logic [N_PHASES-1:0] demand,
  input  logic [IDX_W-1:0]    cur_idx,
  output logic [IDX_W-1:0]    next_idx,
  output logic                wrap
);

  always_comb begin
    logic             found;
    int               cand;
    logic [IDX_W-1:0] cidx;
    found = 1'b0;
    cand  = 0;
    cidx  = '0;
    next_idx = (int'(cur_idx) == N_PHASES - 1) ? '0 : cur_idx + IDX_W'(1);
    // i == N_PHASES lands back on the current index, so a lone requester is re-served
    for (int i = 1; i <= N_PHASES; i++) begin
      cand = (int'(cur_idx) + i) % N_PHASES;
      cidx = IDX_W'(cand);
      if (!found && demand[cidx]) begin
        next_idx = cidx;
        found    = 1'b1;
      end
    end
    wrap = (next_idx <= cur_idx);
  end

endmodule

// File: rtl/traffic_intersection.sv
// Round-robin controller for N_PHASES signal heads with all-red clearance,
// attention flashing, preset extra green, force-red hold and demand skipping.
module traffic_intersection
  import traffic_pkg::*;
#(
  parameter int N_PHASES      = 4,
  parameter int CLK_PER_SEC   = 2,
  parameter int GREEN_S       = 30,
  parameter int PREF_GREEN_S  = 40,
  parameter int YELLOW_S      = 3,
  parameter int ALLRED_S      = 2,
  parameter int PRESET_STEP_S = 10,
  parameter int PRESET_MAX    = 4,
  parameter int FLASH_CYC     = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          attention,
  input  logic [N_PHASES-1:0]           preferential,
  input  logic [N_PHASES-1:0]           demand,
  input  logic                          preset,
  input  logic                          preset_add,
  input  logic                          force_red,
  output logic [3*N_PHASES-1:0]         leds,
  output logic [$clog2(N_PHASES)-1:0]   active_phase,
  output logic                          cycle_done
);

  localparam int IDX_W      = $clog2(N_PHASES);
  localparam int BASE_MAX_S = (PREF_GREEN_S > GREEN_S) ? PREF_GREEN_S : GREEN_S;
  localparam int GRN_MAX_S  = BASE_MAX_S + PRESET_MAX * PRESET_STEP_S;
  localparam int AUX_MAX_S  = (YELLOW_S > ALLRED_S) ? YELLOW_S : ALLRED_S;
  localparam int MAX_S      = (GRN_MAX_S > AUX_MAX_S) ? GRN_MAX_S : AUX_MAX_S;
  localparam int MAX_CYC    = sec2cyc(MAX_S, CLK_PER_SEC);
  localparam int CNT_W      = $clog2(MAX_CYC + 1);
  localparam int PCNT_W     = $clog2(PRESET_MAX + 1);
  localparam int FL_W       = $clog2(FLASH_CYC + 1);

  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(sec2cyc(YELLOW_S, CLK_PER_SEC));
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(sec2cyc(ALLRED_S, CLK_PER_SEC));

  state_t             state, next_state;
  logic [IDX_W-1:0]   phase, next_phase;
  logic [IDX_W-1:0]   arb_next;
  logic               arb_wrap;
  logic [CNT_W-1:0]   timer, load_val;
  logic               load;
  logic               home_q, home_nxt;
  logic               done_nxt;
  logic [PCNT_W-1:0]  preset_cnt;
  logic               preset_add_q;
  logic [FL_W-1:0]    flash_cnt;
  logic               flash_on;

  function automatic logic [CNT_W-1:0] green_cycles(input logic pref,
                                                    input logic [PCNT_W-1:0] steps);
    int sec;
    sec = (pref ? PREF_GREEN_S : GREEN_S) + int'(steps) * PRESET_STEP_S;
    return CNT_W'(sec2cyc(sec, CLK_PER_SEC));
  endfunction

  phase_arbiter #(
    .N_PHASES (N_PHASES),
    .IDX_W    (IDX_W)
  ) u_arb (
    .demand   (demand),
    .cur_idx  (phase),
    .next_idx (arb_next),
    .wrap     (arb_wrap)
  );

  always_comb begin
    logic [IDX_W-1:0] sel;
    sel        = '0;
    next_state = state;
    next_phase = phase;
    load       = 1'b0;
    load_val   = timer;
    done_nxt   = 1'b0;
    home_nxt   = home_q;
    if (preset) begin
      next_state = PRESET;
    end else if (attention) begin
      next_state = FLASH;
    end else begin
      unique case (state)
        IDLE, PRESET: begin
          next_state = GREEN;
          next_phase = '0;
          home_nxt   = 1'b0;
          load       = 1'b1;
          load_val   = green_cycles(preferential[0], preset_cnt);
        end
        // Leaving attention mode: full clearance, then restart from approach 0
        FLASH: begin
          next_state = ALLRED;
          home_nxt   = 1'b1;
          load       = 1'b1;
          load_val   = ALLRED_LD;
        end
        GREEN: begin
          if (force_red || timer == '0) begin
            next_state = YELLOW;
            load       = 1'b1;
            load_val   = YELLOW_LD;
          end
        end
        YELLOW: begin
          if (timer == '0) begin
            next_state = ALLRED;
            load       = 1'b1;
            load_val   = ALLRED_LD;
          end
        end
        ALLRED: begin
          // Reloading each held cycle keeps the clearance full once force_red drops
          if (force_red) begin
            load     = 1'b1;
            load_val = ALLRED_LD;
          end else if (timer == '0) begin
            sel        = home_q ? '0 : arb_next;
            next_state = GREEN;
            next_phase = sel;
            home_nxt   = 1'b0;
            done_nxt   = home_q | arb_wrap;
            load       = 1'b1;
            load_val   = green_cycles(preferential[sel], preset_cnt);
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= '0;
      timer        <= '0;
      home_q       <= 1'b0;
      cycle_done   <= 1'b0;
      preset_cnt   <= '0;
      preset_add_q <= 1'b0;
      flash_cnt    <= '0;
      flash_on     <= 1'b0;
    end else begin
      state        <= next_state;
      phase        <= next_phase;
      home_q       <= home_nxt;
      cycle_done   <= done_nxt;
      preset_add_q <= preset_add;
      if (load) begin
        timer <= load_val;
      end else if (timer != '0) begin
        timer <= timer - CNT_W'(1);
      end
      if (preset && preset_add && !preset_add_q && preset_cnt != PCNT_W'(PRESET_MAX)) begin
        preset_cnt <= preset_cnt + PCNT_W'(1);
      end
      // Flashing always starts on the dark half
      if (next_state == FLASH && state != FLASH) begin
        flash_cnt <= '0;
        flash_on  <= 1'b0;
      end else if (state == FLASH) begin
        if (flash_cnt == FL_W'(FLASH_CYC - 1)) begin
          flash_cnt <= '0;
          flash_on  <= ~flash_on;
        end else begin
          flash_cnt <= flash_cnt + FL_W'(1);
        end
      end
    end
  end

  always_comb begin
    leds = '0;
    for (int k = 0; k < N_PHASES; k++) begin
      unique case (state)
        GREEN:   leds[3*k +: 3] = (IDX_W'(k) == phase) ? LED_G : LED_R;
        YELLOW:  leds[3*k +: 3] = (IDX_W'(k) == phase) ? LED_Y : LED_R;
        ALLRED:  leds[3*k +: 3] = LED_R;
        FLASH:   leds[3*k +: 3] = flash_on ? LED_Y : LED_OFF;
        default: leds[3*k +: 3] = LED_OFF;
      endcase
    end
  end

  assign active_phase = phase;

endmodule

// File: tb/tb_traffic_intersection.sv
// Directed bench for traffic_intersection with a 3-approach configuration.
module tb_traffic_intersection;

  localparam logic [2:0] LG = 3'b100;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LR = 3'b001;
  localparam logic [8:0] ALL_OFF = 9'b000_000_000;
  localparam logic [8:0] ALL_Y   = 9'b010_010_010;
  localparam logic [8:0] ALL_R   = 9'b001_001_001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       attention = 1'b0;
  logic [2:0] preferential = 3'b000;
  logic [2:0] demand = 3'b111;
  logic       preset = 1'b0;
  logic       preset_add = 1'b0;
  logic       force_red = 1'b0;
  logic [8:0] leds;
  logic [1:0] active_phase;
  logic       cycle_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  traffic_intersection #(
    .N_PHASES      (3),
    .CLK_PER_SEC   (2),
    .GREEN_S       (3),
    .PREF_GREEN_S  (5),
    .YELLOW_S      (1),
    .ALLRED_S      (1),
    .PRESET_STEP_S (2),
    .PRESET_MAX    (4),
    .FLASH_CYC     (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .attention    (attention),
    .preferential (preferential),
    .demand       (demand),
    .preset       (preset),
    .preset_add   (preset_add),
    .force_red    (force_red),
    .leds         (leds),
    .active_phase (active_phase),
    .cycle_done   (cycle_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] one_head(input int idx, input logic [2:0] code);
    logic [8:0] v;
    v = ALL_R;
    for (int k = 0; k < 3; k++) begin
      if (k == idx) v[3*k +: 3] = code;
    end
    return v;
  endfunction

  // n cycles of a fixed light pattern; ph < 0 skips the phase check,
  // done_first < 0 skips the cycle_done check on the first cycle
  task automatic run(input string tag, input logic [8:0] pat, input int n,
                     input int ph, input int done_first);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, 32'(leds), 32'(pat));
      if (ph >= 0) check({tag, "_phase"}, 32'(active_phase), ph);
      if (i == 0) begin
        if (done_first >= 0) check({tag, "_done"}, 32'(cycle_done), done_first);
      end else begin
        check({tag, "_done"}, 32'(cycle_done), 0);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_leds", 32'(leds), 0);
    check("rst_phase", 32'(active_phase), 0);
    check("rst_done", 32'(cycle_done), 0);
    rst = 1'b0;
  endtask

  task automatic pulse_add();
    @(posedge clk);
    #1 preset_add = 1'b1;
    @(posedge clk);
    #1 preset_add = 1'b0;
  endtask

  // At most one head may be non-red unless every head shows the same flash/dark code
  always @(negedge clk) begin
    if (!rst && leds != ALL_OFF && leds != ALL_Y) begin
      int nonred;
      nonred = 0;
      for (int k = 0; k < 3; k++) begin
        if (leds[3*k +: 3] != LR) nonred++;
      end
      check("one_head", 32'(nonred <= 1), 1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("init_leds", 32'(leds), 0);
    check("init_phase", 32'(active_phase), 0);
    check("init_done", 32'(cycle_done), 0);
    rst = 1'b0;

    // Basic round robin
    run("t1_g0", one_head(0, LG), 7, 0, 0);
    run("t1_y0", one_head(0, LY), 3, 0, 0);
    run("t1_r0", ALL_R, 3, 0, 0);
    run("t1_g1", one_head(1, LG), 7, 1, 0);
    run("t1_y1", one_head(1, LY), 3, 1, 0);
    run("t1_r1", ALL_R, 3, 1, 0);
    run("t1_g2", one_head(2, LG), 7, 2, 0);
    run("t1_y2", one_head(2, LY), 3, 2, 0);
    run("t1_r2", ALL_R, 3, 2, 0);
    run("t1_g0b", one_head(0, LG), 2, 0, 1);

    // Preferential green on head 0
    preferential = 3'b001;
    do_reset();
    run("t2_g0", one_head(0, LG), 11, 0, 0);
    run("t2_y0", one_head(0, LY), 3, 0, 0);
    run("t2_r0", ALL_R, 3, 0, 0);
    run("t2_g1", one_head(1, LG), 7, 1, 0);
    preferential = 3'b000;

    // Only head 2 demanding
    demand = 3'b100;
    do_reset();
    run("t3_g0", one_head(0, LG), 7, 0, 0);
    run("t3_y0", one_head(0, LY), 3, 0, 0);
    run("t3_r0", ALL_R, 3, 0, 0);
    run("t3_g2a", one_head(2, LG), 7, 2, 0);
    run("t3_y2a", one_head(2, LY), 3, 2, 0);
    run("t3_r2a", ALL_R, 3, 2, 0);
    run("t3_g2b", one_head(2, LG), 7, 2, 1);
    run("t3_y2b", one_head(2, LY), 3, 2, 0);
    run("t3_r2b", ALL_R, 3, 2, 0);
    run("t3_g2c", one_head(2, LG), 1, 2, 1);
    demand = 3'b111;

    // Preset: two pulses plus one held-high pulse -> 3 steps
    preset = 1'b1;
    do_reset();
    run("t4_off", ALL_OFF, 2, 0, 0);
    pulse_add();
    pulse_add();
    @(posedge clk);
    #1 preset_add = 1'b1;
    run("t4_hold", ALL_OFF, 4, 0, 0);
    @(posedge clk);
    #1 preset = 1'b0;
    preset_add = 1'b0;
    run("t4_last", ALL_OFF, 1, 0, 0);
    run("t4_g0", one_head(0, LG), 19, 0, 0);
    run("t4_y0", one_head(0, LY), 3, 0, 0);
    run("t4_r0", ALL_R, 3, 0, 0);
    run("t4_g1", one_head(1, LG), 19, 1, 0);

    // Preset saturation: six pulses clip at 4 steps
    preset = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) pulse_add();
    @(posedge clk);
    #1 preset = 1'b0;
    run("t4s_last", ALL_OFF, 1, 0, 0);
    run("t4s_g0", one_head(0, LG), 23, 0, 0);
    run("t4s_y0", one_head(0, LY), 1, 0, 0);

    // Attention flashing
    do_reset();
    run("t5_g0", one_head(0, LG), 2, 0, 0);
    @(posedge clk);
    #1 attention = 1'b1;
    run("t5_g0x", one_head(0, LG), 1, 0, 0);
    run("t5_off1", ALL_OFF, 3, -1, 0);
    run("t5_yel1", ALL_Y, 3, -1, 0);
    run("t5_off2", ALL_OFF, 3, -1, 0);
    run("t5_yel2", ALL_Y, 3, -1, 0);
    @(posedge clk);
    #1 attention = 1'b0;
    run("t5_off3", ALL_OFF, 1, -1, 0);
    run("t5_clr", ALL_R, 3, -1, 0);
    run("t5_g0b", one_head(0, LG), 7, 0, -1);

    // Force red raised on the second green cycle
    do_reset();
    run("t6_g0", one_head(0, LG), 1, 0, 0);
    @(posedge clk);
    #1 force_red = 1'b1;
    run("t6_g0x", one_head(0, LG), 1, 0, 0);
    run("t6_y0", one_head(0, LY), 3, 0, 0);
    run("t6_hold", ALL_R, 20, 0, 0);
    @(posedge clk);
    #1 force_red = 1'b0;
    run("t6_clr", ALL_R, 3, 0, 0);
    run("t6_g1", one_head(1, LG), 7, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/traffic_intersection.md
Name: traffic_intersection

Overview:
Multi-approach signal controller and the parametrised successor to the single-head traffic light. It drives N_PHASES signal heads in round-robin order: exactly one approach is in GREEN or YELLOW at a time, and all others show RED, with an all-red clearance between approaches. It keeps the single-head feature set (attention flashing, preferential green, preset extra green, force red) and adds per-approach demand skipping, parametrised durations and status outputs for the supervisory block.

Parameters:
N_PHASES, 4, number of approaches (2..8)
CLK_PER_SEC, 2, clock cycles per second
GREEN_S, 30, normal green time in seconds
PREF_GREEN_S, 40, green time in seconds for an approach whose preferential bit is set
YELLOW_S, 3, yellow time in seconds
ALLRED_S, 2, all-red clearance time in seconds
PRESET_STEP_S, 10, extra green seconds added per preset_add pulse
PRESET_MAX, 4, saturation limit of the preset step count
FLASH_CYC, 3, cycles per half-period of attention flashing

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
attention  in  1  flashing-yellow mode on all heads
preferential  in  N_PHASES  per-approach long-green select
demand  in  N_PHASES  per-approach vehicle request
preset  in  1  configuration mode
preset_add  in  1  increments extra green; edge-detected while preset is high
force_red  in  1  drive the intersection to all-red and hold
leds  out  3*N_PHASES  head k at bits [3k+2:3k] = {G,Y,R}
active_phase  out  $clog2(N_PHASES)  approach currently served
cycle_done  out  1  one-cycle pulse on ALLRED exit after the last served approach

Behaviour:
- Reset is synchronous and active-high on clk. While rst=1: all leds=0, active_phase=0, cycle_done=0, preset count=0, state=IDLE. Reset mid-operation aborts any timer.
- Priority, evaluated every cycle: rst > preset > attention > force_red > normal sequencing.
- States: IDLE, GREEN, YELLOW, ALLRED, FLASH, PRESET.
- IDLE is left on the first cycle with rst=0. It enters GREEN on approach 0, so approach 0 shows 100 and all others 001 at the first negedge after rst deasserts.
- Timer: one down-counter of width CNT_W = $clog2(max cycles + 1), held as a localparam. It is loaded with dur*CLK_PER_SEC on state entry and decremented each cycle. The state transitions on the cycle after the counter reaches 0, so every state lasts dur*CLK_PER_SEC+1 cycles.
- GREEN duration = (preferential[k] ? PREF_GREEN_S : GREEN_S) + cnt*PRESET_STEP_S. preferential is sampled on GREEN entry.
- GREEN -> YELLOW -> ALLRED -> GREEN(next approach).
- Next approach = next index, with wrap-around, whose demand bit is 1. If demand is all zero, advance to index+1 unconditionally. If the only demanding approach is the current one, it is re-served after ALLRED.
- cycle_done pulses when the next approach index is at or below the current one (wrap).
- PRESET: all leds=0. Each 0->1 edge of preset_add increments cnt, saturating at PRESET_MAX. When preset falls, the block enters GREEN on approach 0. cnt survives everything except rst.
- FLASH: all heads toggle between 000 and 010. The first FLASH_CYC cycles show 000, the next FLASH_CYC show 010, and so on. When attention falls, the block enters ALLRED with a full clearance, then GREEN on approach 0.
- force_red while in GREEN: go to YELLOW immediately (full yellow), then ALLRED. The block holds ALLRED with the timer frozen at its load value while force_red=1. After release it runs the full clearance, then serves the next approach. force_red during YELLOW or ALLRED: the current sequence runs to completion and the block holds in ALLRED.
- Never more than one head is non-red outside FLASH and PRESET; this is a bench assertion.

Decomposition:
- Package traffic_pkg: enum state_t {IDLE, GREEN, YELLOW, ALLRED, FLASH, PRESET}; light encoding constants LED_OFF=3'b000, LED_G=3'b100, LED_Y=3'b010, LED_R=3'b001; function sec2cyc.
- Sub-module phase_arbiter (combinational): takes demand and the current index, and returns the next index and the wrap flag.

Test Plan:
Use N_PHASES=3, CLK_PER_SEC=2, GREEN_S=3, PREF_GREEN_S=5, YELLOW_S=1, ALLRED_S=1, PRESET_STEP_S=2, with demand=3'b111 unless stated otherwise.
1. Release rst -> head0 100 for 7 cycles, then 010 for 3, then all 001 for 3. Head1 then shows 100 and active_phase=1. After head2, cycle_done pulses once and head0 is green again.
2. preferential=3'b001 -> head0 green for 11 cycles; head1 green for 7.
3. demand=3'b100 -> after head0's initial green, every subsequent green goes to head2 only. cycle_done pulses each ALLRED exit.
4. rst, then preset=1 with two preset_add pulses (and a third held high, which counts once) -> leds all 0. After preset falls, head0 green lasts (3+6)*2+1=19 cycles.
5. attention=1 -> all heads 000 for 3 cycles, then 010 for 3, repeating. Dropping attention -> all 001 for 3 cycles, then head0 100.
6. force_red raised on the 2nd GREEN cycle -> 010 for 3 cycles, then all 001 for as long as force_red is held (checked for 20 cycles). After release: 3 more all-red cycles, then head1 100.
